memory_access_stage: RTL and testbench

//  MEM stage of the 5-stage RISC-V pipeline; feeds the memory_writeback_if that the writeback stage consumes.

---
 rtl/memory_access_stage_if.sv | 54 +++++
 rtl/memory_access_stage.sv | 187 ++++++++++++++++++
 tb/tb_memory_access_stage.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/memory_access_stage_if.sv
// Interface bundling the MEM stage's EX/MEM input record, data-memory bus and MEM/WB record.
// Signals:
//   ex_*    EX/MEM record in, ex_ready back-pressure out
//   dmem_*  req/ack data-memory bus (stage is the bus master)
//   mw_*    registered MEM/WB record consumed by writeback
// Modports: master = the MEM stage, slave = its environment (EX, memory, WB).
interface memory_access_stage_if;
  logic        ex_valid;
  logic        ex_ready;
  logic [31:0] ex_alu_result;
  logic [31:0] ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_reg_write;
  logic        ex_mem_read;
  logic        ex_mem_write;
  logic [2:0]  ex_funct3;

  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  logic        mw_valid;
  logic [31:0] mw_address;
  logic [31:0] mw_LMD;
  logic        mw_mem_to_reg;
  logic [4:0]  mw_rd_addr;
  logic        mw_reg_write;
  logic        mw_misalign;
  logic        mw_bus_err;

  modport master (
    input  ex_valid, ex_alu_result, ex_store_data, ex_rd_addr, ex_reg_write,
    input  ex_mem_read, ex_mem_write, ex_funct3,
    output ex_ready,
    output dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    input  dmem_ack, dmem_rdata,
    output mw_valid, mw_address, mw_LMD, mw_mem_to_reg, mw_rd_addr, mw_reg_write,
    output mw_misalign, mw_bus_err
  );

  modport slave (
    output ex_valid, ex_alu_result, ex_store_data, ex_rd_addr, ex_reg_write,
    output ex_mem_read, ex_mem_write, ex_funct3,
    input  ex_ready,
    input  dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata,
    output dmem_ack, dmem_rdata,
    input  mw_valid, mw_address, mw_LMD, mw_mem_to_reg, mw_rd_addr, mw_reg_write,
    input  mw_misalign, mw_bus_err
  );
endinterface

// File: rtl/memory_access_stage.sv
// MEM stage of the 5-stage RISC-V pipeline.
// Accepts one EX/MEM record at a time, performs any load/store on the req/ack data bus,
// aligns/extends load data and emits a one-cycle registered MEM/WB record.
// Ports:
//   clk  clock (posedge)
//   rst  synchronous active-high reset
//   bus  memory_access_stage_if.master: ex_* in / ex_ready out, dmem_* bus, mw_* record out
module memory_access_stage #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned MEM_TIMEOUT = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  memory_access_stage_if.master bus
);

  localparam int unsigned TimerW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [TimerW-1:0] TimerMax = TimerW'(MEM_TIMEOUT - 1);

  typedef enum logic [0:0] {StIdle, StAccess} state_e;

  // funct3[1:0]: 00 byte, 01 half, 1x word; funct3[2] selects zero-extension.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 1'b0;
      2'b01:   return lo[0];
      default: return lo != 2'b00;
    endcase
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] store_wdata(input logic [2:0] f3, input logic [XLEN-1:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  function automatic logic [XLEN-1:0] load_extend(input logic [2:0] f3, input logic [1:0] lo,
                                                  input logic [XLEN-1:0] rdata);
    logic [7:0]  b;
    logic [15:0] h;
    b = rdata[{lo, 3'b000} +: 8];
    h = rdata[{lo[1], 4'b0000} +: 16];
    case (f3[1:0])
      2'b00:   return f3[2] ? {{(XLEN-8){1'b0}}, b} : {{(XLEN-8){b[7]}}, b};
      2'b01:   return f3[2] ? {{(XLEN-16){1'b0}}, h} : {{(XLEN-16){h[15]}}, h};
      default: return rdata;
    endcase
  endfunction

  state_e            state_q;
  logic              ready_q;
  logic [TimerW-1:0] timer_q;
  logic              req_q, we_q;
  logic [XLEN-1:0]   addr_q, wdata_q;
  logic [3:0]        be_q;
  // Pending-access context needed when the ack returns.
  logic [2:0]        f3_q;
  logic [1:0]        lane_q;
  logic              load_q, wen_q;

  logic              mw_valid_q, mw_mem_to_reg_q, mw_reg_write_q, mw_misalign_q, mw_bus_err_q;
  logic [XLEN-1:0]   mw_address_q, mw_lmd_q;
  logic [4:0]        mw_rd_addr_q;

  logic              accept, is_mem, misalign, wen;
  logic [XLEN-1:0]   ack_lmd;

  always_comb begin
    accept   = bus.ex_valid && ready_q;
    is_mem   = bus.ex_mem_read || bus.ex_mem_write;
    misalign = is_mem && is_misaligned(bus.ex_funct3, bus.ex_alu_result[1:0]);
    // Stores never write the register file; x0 is never written.
    wen      = bus.ex_reg_write && (bus.ex_rd_addr != 5'd0) && !bus.ex_mem_write;
    ack_lmd  = load_extend(f3_q, lane_q, bus.dmem_rdata);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= StIdle;
      ready_q         <= 1'b0;
      timer_q         <= '0;
      req_q           <= 1'b0;
      we_q            <= 1'b0;
      addr_q          <= '0;
      wdata_q         <= '0;
      be_q            <= '0;
      f3_q            <= '0;
      lane_q          <= '0;
      load_q          <= 1'b0;
      wen_q           <= 1'b0;
      mw_valid_q      <= 1'b0;
      mw_address_q    <= '0;
      mw_lmd_q        <= '0;
      mw_mem_to_reg_q <= 1'b0;
      mw_rd_addr_q    <= '0;
      mw_reg_write_q  <= 1'b0;
      mw_misalign_q   <= 1'b0;
      mw_bus_err_q    <= 1'b0;
    end else begin
      mw_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          ready_q <= 1'b1;
          if (accept) begin
            mw_address_q <= bus.ex_alu_result;
            mw_rd_addr_q <= bus.ex_rd_addr;
            if (!is_mem || misalign) begin
              // Completes without touching the bus.
              mw_valid_q      <= 1'b1;
              mw_lmd_q        <= '0;
              mw_mem_to_reg_q <= bus.ex_mem_read && !misalign;
              mw_reg_write_q  <= wen && !misalign;
              mw_misalign_q   <= misalign;
              mw_bus_err_q    <= 1'b0;
            end else begin
              state_q <= StAccess;
              ready_q <= 1'b0;
              timer_q <= '0;
              req_q   <= 1'b1;
              we_q    <= bus.ex_mem_write;
              addr_q  <= {bus.ex_alu_result[XLEN-1:2], 2'b00};
              be_q    <= store_be(bus.ex_funct3, bus.ex_alu_result[1:0]);
              wdata_q <= bus.ex_mem_write ? store_wdata(bus.ex_funct3, bus.ex_store_data) : '0;
              f3_q    <= bus.ex_funct3;
              lane_q  <= bus.ex_alu_result[1:0];
              load_q  <= bus.ex_mem_read;
              wen_q   <= wen;
            end
          end
        end
        StAccess: begin
          // Ack has priority over a timeout in the same cycle.
          if (bus.dmem_ack) begin
            state_q         <= StIdle;
            ready_q         <= 1'b1;
            req_q           <= 1'b0;
            mw_valid_q      <= 1'b1;
            mw_lmd_q        <= load_q ? ack_lmd : '0;
            mw_mem_to_reg_q <= load_q;
            mw_reg_write_q  <= wen_q;
            mw_misalign_q   <= 1'b0;
            mw_bus_err_q    <= 1'b0;
          end else if (timer_q == TimerMax) begin
            state_q         <= StIdle;
            ready_q         <= 1'b1;
            req_q           <= 1'b0;
            mw_valid_q      <= 1'b1;
            mw_lmd_q        <= '0;
            mw_mem_to_reg_q <= load_q;
            mw_reg_write_q  <= 1'b0;
            mw_misalign_q   <= 1'b0;
            mw_bus_err_q    <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.ex_ready      = ready_q;
  assign bus.dmem_req      = req_q;
  assign bus.dmem_we       = we_q;
  assign bus.dmem_addr     = addr_q;
  assign bus.dmem_be       = be_q;
  assign bus.dmem_wdata    = wdata_q;
  assign bus.mw_valid      = mw_valid_q;
  assign bus.mw_address    = mw_address_q;
  assign bus.mw_LMD        = mw_lmd_q;
  assign bus.mw_mem_to_reg = mw_mem_to_reg_q;
  assign bus.mw_rd_addr    = mw_rd_addr_q;
  assign bus.mw_reg_write  = mw_reg_write_q;
  assign bus.mw_misalign   = mw_misalign_q;
  assign bus.mw_bus_err    = mw_bus_err_q;

endmodule

// File: tb/tb_memory_access_stage.sv
// Testbench for memory_access_stage: directed cases followed by randomized operations,
// each checked against a behavioural model of the MEM stage rules.
module tb_memory_access_stage;
  localparam int Timeout = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  memory_access_stage_if bus ();

  memory_access_stage #(.XLEN(32), .MEM_TIMEOUT(Timeout)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk(tag, {31'd0, |{bus.ex_ready, bus.dmem_req, bus.dmem_we, bus.dmem_addr, bus.dmem_be,
                       bus.dmem_wdata, bus.mw_valid, bus.mw_address, bus.mw_LMD,
                       bus.mw_mem_to_reg, bus.mw_rd_addr, bus.mw_reg_write, bus.mw_misalign,
                       bus.mw_bus_err}}, 32'd0);
  endtask

  task automatic scramble_ex();
    bus.ex_alu_result = $urandom;
    bus.ex_store_data = $urandom;
    bus.ex_rd_addr    = 5'($urandom);
    bus.ex_reg_write  = 1'($urandom);
    bus.ex_mem_read   = 1'($urandom);
    bus.ex_mem_write  = 1'b0;
    bus.ex_funct3     = 3'($urandom);
  endtask

  // Called just after a negedge with the stage ready. ack_after = number of waiting cycles
  // before ack (<0 or >= Timeout means the memory never answers in time).
  task automatic run_op(input string name, input logic [31:0] addr, input logic [31:0] sdata,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic mw,
                        input logic [2:0] f3, input logic [31:0] rdata, input int ack_after);
    int          bytes, lane, n;
    logic        mem, mis, berr, done, fin;
    longint      mask;
    logic [31:0] exp_be, exp_wd, exp_lmd, v;
    // Reference model
    mem   = mr || mw;
    bytes = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
    lane  = int'(addr % 4);
    mis   = mem && ((addr % bytes) != 0);
    berr  = mem && !mis && (ack_after < 0 || ack_after >= Timeout);
    mask  = (64'd1 << (8 * bytes)) - 1;
    exp_be = 32'(((1 << bytes) - 1) << lane);
    exp_wd = 32'd0;
    for (int k = 0; k < 4 / bytes; k++)
      exp_wd = exp_wd | 32'((longint'(sdata) & mask) << (8 * bytes * k));
    v = 32'((longint'(rdata) >> (8 * lane)) & mask);
    if (bytes < 4 && !f3[2] && longint'(v) >= (mask + 1) / 2) v = v | ~32'(mask);
    exp_lmd = (mr && !mis && !berr) ? v : 32'd0;

    chk({name, ":ready"}, bus.ex_ready, 1);
    bus.ex_valid      = 1'b1;
    bus.ex_alu_result = addr;
    bus.ex_store_data = sdata;
    bus.ex_rd_addr    = rd;
    bus.ex_reg_write  = rw;
    bus.ex_mem_read   = mr;
    bus.ex_mem_write  = mw;
    bus.ex_funct3     = f3;
    bus.dmem_ack      = 1'($urandom);
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    bus.dmem_ack = 1'b0;
    scramble_ex();
    @(negedge clk);
    if (mem && !mis) begin
      chk({name, ":mw_valid_wait"}, bus.mw_valid, 0);
      n    = 0;
      done = 1'b0;
      while (!done) begin
        chk({name, ":req"}, bus.dmem_req, 1);
        chk({name, ":ready_busy"}, bus.ex_ready, 0);
        chk({name, ":we"}, bus.dmem_we, mw);
        chk({name, ":addr"}, bus.dmem_addr, addr - 32'(lane));
        if (mw) begin
          chk({name, ":be"}, bus.dmem_be, exp_be);
          chk({name, ":wdata"}, bus.dmem_wdata, exp_wd);
        end
        fin = (n == ack_after) || (n == Timeout - 1);
        scramble_ex();
        bus.ex_valid = fin ? 1'b0 : 1'($urandom);
        if (n == ack_after) begin
          bus.dmem_ack   = 1'b1;
          bus.dmem_rdata = rdata;
        end
        @(posedge clk);
        #1;
        bus.dmem_ack   = 1'b0;
        bus.dmem_rdata = $urandom;
        bus.ex_valid   = 1'b0;
        done = fin;
        n++;
        @(negedge clk);
      end
      chk({name, ":req_drop"}, bus.dmem_req, 0);
    end
    chk({name, ":mw_valid"}, bus.mw_valid, 1);
    chk({name, ":mw_address"}, bus.mw_address, addr);
    chk({name, ":mw_LMD"}, bus.mw_LMD, exp_lmd);
    chk({name, ":mw_mem_to_reg"}, bus.mw_mem_to_reg, mr && !mis);
    chk({name, ":mw_rd_addr"}, bus.mw_rd_addr, rd);
    chk({name, ":mw_reg_write"}, bus.mw_reg_write, rw && rd != 0 && !mw && !mis && !berr);
    chk({name, ":mw_misalign"}, bus.mw_misalign, mis);
    chk({name, ":mw_bus_err"}, bus.mw_bus_err, berr);
    chk({name, ":ready_after"}, bus.ex_ready, 1);
  endtask

  initial begin
    logic [2:0]  f3_tab [8];
    logic [2:0]  f3;
    logic [31:0] a;
    int          kind, r, ack;
    f3_tab = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5, 3'd3, 3'd6, 3'd7};

    rst = 1'b1;
    bus.ex_valid   = 1'b0;
    bus.dmem_ack   = 1'b0;
    bus.dmem_rdata = 32'd0;
    scramble_ex();
    repeat (3) @(negedge clk);
    chk_all_zero("reset_outputs");
    rst = 1'b0;
    @(negedge clk);

    // Directed cases
    run_op("alu", 32'h1234_5678, 32'h0, 5'd1, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 0);
    run_op("lb", 32'h0000_1003, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 3'b000, 32'h80FF_FFFF, 3);
    run_op("lbu", 32'h0000_1003, 32'h0, 5'd2, 1'b1, 1'b1, 1'b0, 3'b100, 32'h80FF_FFFF, 3);
    run_op("sh", 32'h0000_2002, 32'h0000_BEEF, 5'd3, 1'b1, 1'b0, 1'b1, 3'b001, 32'h0, 2);
    run_op("lw_mis", 32'h0000_3001, 32'h0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0, 0);
    run_op("lw_x0", 32'h0000_3000, 32'h0, 5'd0, 1'b1, 1'b1, 1'b0, 3'b010, 32'hCAFE_F00D, 1);
    run_op("lw_tmo", 32'h0000_4000, 32'h0, 5'd5, 1'b1, 1'b1, 1'b0, 3'b010, 32'h0, -1);
    run_op("alu_after_tmo", 32'h0000_00AA, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0, 3'd0, 32'h0, 0);
    run_op("lh_ack_last", 32'h0000_5002, 32'h0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b001, 32'h8001_0000,
           Timeout - 1);
    run_op("sb", 32'h0000_6001, 32'h1234_56A5, 5'd8, 1'b1, 1'b0, 1'b1, 3'b000, 32'h0, 0);

    // Reset in the middle of an access, memory answers one cycle later.
    bus.ex_valid      = 1'b1;
    bus.ex_alu_result = 32'h0000_0040;
    bus.ex_rd_addr    = 5'd9;
    bus.ex_reg_write  = 1'b1;
    bus.ex_mem_read   = 1'b1;
    bus.ex_mem_write  = 1'b0;
    bus.ex_funct3     = 3'b010;
    @(posedge clk);
    #1;
    bus.ex_valid = 1'b0;
    @(negedge clk);
    chk("rst_mid:req", bus.dmem_req, 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk_all_zero("rst_mid:outputs");
    @(negedge clk);
    rst            = 1'b0;
    bus.dmem_ack   = 1'b1;
    bus.dmem_rdata = 32'hDEAD_BEEF;
    @(posedge clk);
    #1;
    bus.dmem_ack = 1'b0;
    @(negedge clk);
    chk("rst_mid:no_mw_valid", bus.mw_valid, 0);
    chk("rst_mid:req_low", bus.dmem_req, 0);
    run_op("after_rst", 32'h0000_0044, 32'h0, 5'd10, 1'b1, 1'b1, 1'b0, 3'b101,
           32'h1234_ABCD, 2);

    // Randomized operations
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom % 3);
      a    = $urandom;
      f3   = (kind == 2) ? f3_tab[$urandom % 3] : f3_tab[$urandom % 8];
      if ($urandom % 2 == 1) a = a & ~32'(f3[1] ? 3 : f3[0] ? 1 : 0);
      r   = int'($urandom % 10);
      ack = (r == 0) ? -1 : (r == 1) ? Timeout - 1 : int'($urandom % 5);
      run_op("rand", a, $urandom, ($urandom % 4 == 0) ? 5'd0 : 5'($urandom), 1'($urandom),
             kind == 1, kind == 2, f3, $urandom, ack);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
